// File: rtl/uart_com_port.sv
// uart_com_port: 8N1 UART beneath the debug controller.
//  RX: 2-flop synchroniser, start-bit mid-point qualification, LSB-first
//      deserialiser, one-byte holding register with read_ready/rx_ack handshake,
//      sticky overrun and a one-cycle frame_err pulse on a low stop bit.
//  TX: one byte per accepted tx_we, registered glitch-free txd. write_ready
//      re-arms only after tx_we is seen low, so a held tx_we sends one byte.
// Ports:
//  clk, rst (async, active-high)
//  rxd in / txd out          serial lines, idle high
//  rx_data, read_ready, rx_ack, overrun, frame_err   receive side
//  tx_data, tx_we, write_ready                       transmit side
module uart_com_port #(
  parameter int CLK_DIV = 434
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd,
  output logic       txd,
  output logic [7:0] rx_data,
  output logic       read_ready,
  input  logic       rx_ack,
  output logic       overrun,
  output logic       frame_err,
  input  logic [7:0] tx_data,
  input  logic       tx_we,
  output logic       write_ready
);
  localparam int CW = $clog2(CLK_DIV);
  localparam logic [CW-1:0] BIT_END  = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] HALF_END = CW'(CLK_DIV / 2 - 1);

  typedef enum logic [2:0] {R_IDLE, R_START, R_DATA, R_STOP, R_BREAK} rx_state_t;
  typedef enum logic [1:0] {T_IDLE, T_START, T_DATA, T_STOP} tx_state_t;

  // ---------------- RX ----------------
  logic            rx_s1, rx_s2;
  rx_state_t       rx_state, rx_state_n;
  logic [CW-1:0]   rx_cnt, rx_cnt_n;
  logic [2:0]      rx_bit, rx_bit_n;
  logic [7:0]      rx_shift, rx_shift_n;
  logic [7:0]      rx_data_n;
  logic            rr_n, ovr_n, fe_n, rx_done;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_s1      <= 1'b1;
      rx_s2      <= 1'b1;
      rx_state   <= R_IDLE;
      rx_cnt     <= '0;
      rx_bit     <= '0;
      rx_shift   <= '0;
      rx_data    <= '0;
      read_ready <= 1'b0;
      overrun    <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      rx_s1      <= rxd;
      rx_s2      <= rx_s1;
      rx_state   <= rx_state_n;
      rx_cnt     <= rx_cnt_n;
      rx_bit     <= rx_bit_n;
      rx_shift   <= rx_shift_n;
      rx_data    <= rx_data_n;
      read_ready <= rr_n;
      overrun    <= ovr_n;
      frame_err  <= fe_n;
    end
  end

  always_comb begin
    rx_state_n = rx_state;
    rx_cnt_n   = rx_cnt;
    rx_bit_n   = rx_bit;
    rx_shift_n = rx_shift;
    rx_done    = 1'b0;
    fe_n       = 1'b0;
    case (rx_state)
      R_IDLE:
        if (!rx_s2) begin
          rx_state_n = R_START;
          rx_cnt_n   = '0;
        end
      R_START:
        // Half-bit check rejects glitches and sets the mid-bit sampling phase.
        if (rx_cnt == HALF_END) begin
          rx_cnt_n   = '0;
          rx_bit_n   = '0;
          rx_state_n = rx_s2 ? R_IDLE : R_DATA;
        end else rx_cnt_n = rx_cnt + 1'b1;
      R_DATA:
        if (rx_cnt == BIT_END) begin
          rx_cnt_n   = '0;
          rx_shift_n = {rx_s2, rx_shift[7:1]};
          rx_bit_n   = rx_bit + 3'd1;
          if (rx_bit == 3'd7) rx_state_n = R_STOP;
        end else rx_cnt_n = rx_cnt + 1'b1;
      R_STOP:
        if (rx_cnt == BIT_END) begin
          rx_cnt_n = '0;
          if (rx_s2) begin
            rx_done    = 1'b1;
            rx_state_n = R_IDLE;
          end else begin
            fe_n       = 1'b1;
            rx_state_n = R_BREAK;
          end
        end else rx_cnt_n = rx_cnt + 1'b1;
      R_BREAK:
        if (rx_s2) rx_state_n = R_IDLE;
      default: rx_state_n = R_IDLE;
    endcase

    // Holding register. A completing byte and an ack in the same cycle
    // count as consume-then-load, so read_ready stays high.
    rx_data_n = rx_data;
    rr_n      = read_ready;
    ovr_n     = overrun;
    if (read_ready && rx_ack) begin
      rr_n  = 1'b0;
      ovr_n = 1'b0;
    end
    if (rx_done) begin
      if (!read_ready || rx_ack) begin
        rx_data_n = rx_shift;
        rr_n      = 1'b1;
      end else ovr_n = 1'b1;
    end
  end

  // ---------------- TX ----------------
  tx_state_t       tx_state, tx_state_n;
  logic [CW-1:0]   tx_cnt, tx_cnt_n;
  logic [2:0]      tx_bit, tx_bit_n;
  logic [7:0]      tx_shift, tx_shift_n;
  logic            txd_n, armed, armed_n;

  assign write_ready = armed;  // armed can only be set while idle

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_state <= T_IDLE;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_shift <= '0;
      txd      <= 1'b1;
      armed    <= 1'b1;
    end else begin
      tx_state <= tx_state_n;
      tx_cnt   <= tx_cnt_n;
      tx_bit   <= tx_bit_n;
      tx_shift <= tx_shift_n;
      txd      <= txd_n;
      armed    <= armed_n;
    end
  end

  always_comb begin
    tx_state_n = tx_state;
    tx_cnt_n   = tx_cnt;
    tx_bit_n   = tx_bit;
    tx_shift_n = tx_shift;
    txd_n      = txd;
    armed_n    = armed;
    case (tx_state)
      T_IDLE:
        if (tx_we && armed) begin
          tx_shift_n = tx_data;
          armed_n    = 1'b0;
          tx_cnt_n   = '0;
          txd_n      = 1'b0;
          tx_state_n = T_START;
        end else if (!tx_we) armed_n = 1'b1;
      T_START:
        if (tx_cnt == BIT_END) begin
          tx_cnt_n   = '0;
          tx_bit_n   = '0;
          txd_n      = tx_shift[0];
          tx_state_n = T_DATA;
        end else tx_cnt_n = tx_cnt + 1'b1;
      T_DATA:
        if (tx_cnt == BIT_END) begin
          tx_cnt_n = '0;
          if (tx_bit == 3'd7) begin
            txd_n      = 1'b1;
            tx_state_n = T_STOP;
          end else begin
            tx_bit_n   = tx_bit + 3'd1;
            tx_shift_n = {1'b0, tx_shift[7:1]};
            txd_n      = tx_shift[1];
          end
        end else tx_cnt_n = tx_cnt + 1'b1;
      T_STOP:
        // Re-arm directly at frame end when tx_we is already low so the
        // busy window is exactly one frame long.
        if (tx_cnt == BIT_END) begin
          tx_cnt_n   = '0;
          armed_n    = !tx_we;
          tx_state_n = T_IDLE;
        end else tx_cnt_n = tx_cnt + 1'b1;
      default: tx_state_n = T_IDLE;
    endcase
  end
endmodule

// File: tb/tb_uart_com_port.sv
// Self-checking bench for uart_com_port at CLK_DIV=16: randomized RX/TX bytes
// checked against a small handshake model and an ideal 8N1 waveform.
module tb_uart_com_port;
  localparam int DIV = 16;

  logic       clk = 1'b0, rst = 1'b1, rxd = 1'b1, rx_ack = 1'b0, tx_we = 1'b0;
  logic [7:0] tx_data = '0;
  logic       txd, read_ready, overrun, frame_err, write_ready;
  logic [7:0] rx_data;

  uart_com_port #(.CLK_DIV(DIV)) dut (
    .clk(clk), .rst(rst), .rxd(rxd), .txd(txd), .rx_data(rx_data),
    .read_ready(read_ready), .rx_ack(rx_ack), .overrun(overrun),
    .frame_err(frame_err), .tx_data(tx_data), .tx_we(tx_we),
    .write_ready(write_ready)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;
  int cyc = 0, fe_cnt = 0, rr_rise = 0;
  logic rr_q = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    rr_q <= read_ready;
    if (read_ready === 1'b1 && rr_q !== 1'b1) rr_rise <= cyc;
    if (frame_err === 1'b1) fe_cnt <= fe_cnt + 1;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Receive-side model: what the holding register should show.
  logic       exp_ready = 1'b0, exp_ovr = 1'b0;
  logic [7:0] exp_data = '0;

  function automatic void m_byte(input logic [7:0] b, input logic ack);
    if (!exp_ready || ack) begin
      exp_data  = b;
      exp_ready = 1'b1;
      if (ack) exp_ovr = 1'b0;
    end else exp_ovr = 1'b1;
  endfunction

  function automatic void m_ack();
    if (exp_ready) begin
      exp_ready = 1'b0;
      exp_ovr   = 1'b0;
    end
  endfunction

  function automatic void m_reset();
    exp_ready = 1'b0; exp_ovr = 1'b0; exp_data = '0;
  endfunction

  // Ideal transmit waveform: frame bit k of byte b (start, d0..d7, stop).
  function automatic logic frame_bit(input logic [7:0] b, input int k);
    if (k == 0) return 1'b0;
    if (k == 9) return 1'b1;
    return b[k-1];
  endfunction

  task automatic send_rx(input logic [7:0] b, input logic stop_bit, output int t0);
    @(negedge clk); rxd = 1'b0; t0 = cyc;
    repeat (DIV) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      repeat (DIV) @(negedge clk);
    end
    rxd = stop_bit;
    repeat (DIV) @(negedge clk);
    rxd = 1'b1;
  endtask

  task automatic pulse_ack();
    @(negedge clk); rx_ack = 1'b1;
    @(negedge clk); rx_ack = 1'b0;
    m_ack();
  endtask

  task automatic check_rx(input string tag);
    checks++;
    if (read_ready !== exp_ready) begin
      failures++; $display("FAIL %s read_ready got=%b exp=%b", tag, read_ready, exp_ready);
    end
    checks++;
    if (overrun !== exp_ovr) begin
      failures++; $display("FAIL %s overrun got=%b exp=%b", tag, overrun, exp_ovr);
    end
    if (exp_ready) begin
      checks++;
      if (rx_data !== exp_data) begin
        failures++; $display("FAIL %s rx_data got=%h exp=%h", tag, rx_data, exp_data);
      end
    end
  endtask

  // Drives tx_we for `hold` cycles plus one stray pulse at `stray`, records
  // 240 cycles of txd/write_ready and compares against one ideal frame.
  task automatic tx_frame(input logic [7:0] b, input int hold, input int stray);
    logic ts [0:239];
    int wr_low, bad_bit, bad_idle;
    wr_low = 0; bad_bit = -1; bad_idle = 0;
    for (int i = 0; i < 240; i++) begin
      @(negedge clk);
      ts[i] = txd;
      if (write_ready === 1'b0) wr_low++;
      tx_data = b;
      tx_we   = (i < hold) || (i == stray);
    end
    tx_we = 1'b0;
    for (int k = 0; k < 10; k++) begin
      checks++;
      for (int j = 0; j < DIV; j++)
        if (ts[1 + k*DIV + j] !== frame_bit(b, k) && bad_bit < 0) bad_bit = k;
      if (bad_bit == k) begin
        failures++;
        $display("FAIL tx_bit%0d byte=%h got=%b exp=%b", k, b, ts[1 + k*DIV], frame_bit(b, k));
      end
    end
    for (int i = 161; i < 240; i++) if (ts[i] !== 1'b1) bad_idle++;
    checks++;
    if (ts[0] !== 1'b1 || bad_idle != 0) begin
      failures++; $display("FAIL tx_idle byte=%h low_samples=%0d exp=0", b, bad_idle);
    end
    checks++;
    if (wr_low != 10*DIV) begin
      failures++; $display("FAIL tx_write_ready_low got=%0d exp=%0d", wr_low, 10*DIV);
    end
    checks++;
    if (write_ready !== 1'b1) begin
      failures++; $display("FAIL tx_rearm write_ready got=%b exp=1", write_ready);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if ({txd, write_ready, read_ready, overrun, frame_err} !== 5'b11000 || rx_data !== 8'h00) begin
      failures++;
      $display("FAIL reset txd/wr/rr/ovr/fe got=%b%b%b%b%b rx_data=%h exp=11000/00",
               txd, write_ready, read_ready, overrun, frame_err, rx_data);
    end
    rst = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_rx_basic();
    int t0;
    logic [7:0] b;
    for (int n = 0; n < 5; n++) begin
      b = (n == 0) ? 8'h43 : 8'($urandom);
      send_rx(b, 1'b1, t0);
      m_byte(b, 1'b0);
      checks++;
      if (rr_rise - t0 < 152 || rr_rise - t0 > 156) begin
        failures++; $display("FAIL rx_latency got=%0d exp=152..156", rr_rise - t0);
      end
      check_rx("rx_basic");
      pulse_ack();
      check_rx("rx_basic_ack");
      repeat ($urandom_range(1, 20)) @(negedge clk);
    end
  endtask

  task automatic test_glitch();
    int t0, fe0;
    logic [7:0] b;
    fe0 = fe_cnt;
    pulse_ack();  // ack with nothing held must be ignored
    @(negedge clk); rxd = 1'b0;
    repeat (4) @(negedge clk);
    rxd = 1'b1;
    repeat (40) @(negedge clk);
    check_rx("glitch");
    checks++;
    if (fe_cnt != fe0) begin
      failures++; $display("FAIL glitch frame_err cycles got=%0d exp=0", fe_cnt - fe0);
    end
    b = 8'($urandom);
    send_rx(b, 1'b1, t0);
    m_byte(b, 1'b0);
    check_rx("after_glitch");
    pulse_ack();
  endtask

  task automatic test_overrun();
    int t0;
    send_rx(8'h31, 1'b1, t0); m_byte(8'h31, 1'b0);
    repeat (5) @(negedge clk);
    send_rx(8'h32, 1'b1, t0); m_byte(8'h32, 1'b0);
    check_rx("overrun");
    pulse_ack();
    check_rx("overrun_ack");
    repeat (5) @(negedge clk);
    // Ack lands on the cycle the second byte completes.
    send_rx(8'h31, 1'b1, t0); m_byte(8'h31, 1'b0);
    repeat (5) @(negedge clk);
    fork
      send_rx(8'h32, 1'b1, t0);
      begin
        repeat (154) @(negedge clk);
        rx_ack = 1'b1;
        @(negedge clk); rx_ack = 1'b0;
      end
    join
    m_byte(8'h32, 1'b1);
    check_rx("ack_on_complete");
    pulse_ack();
    check_rx("ack_on_complete_clear");
  endtask

  task automatic test_frame_err();
    int t0, fe0;
    logic [7:0] b;
    for (int n = 0; n < 2; n++) begin
      fe0 = fe_cnt;
      b = (n == 0) ? 8'h55 : 8'($urandom);
      send_rx(b, 1'b0, t0);
      repeat (20) @(negedge clk);
      checks++;
      if (fe_cnt - fe0 != 1) begin
        failures++; $display("FAIL frame_err cycles got=%0d exp=1", fe_cnt - fe0);
      end
      check_rx("frame_err");
      b = (n == 0) ? 8'hA5 : 8'($urandom);
      send_rx(b, 1'b1, t0); m_byte(b, 1'b0);
      check_rx("after_frame_err");
      pulse_ack();
    end
  endtask

  task automatic test_tx();
    tx_frame(8'h41, 3, 60);
    for (int n = 0; n < 3; n++) begin
      repeat ($urandom_range(1, 10)) @(negedge clk);
      tx_frame(8'($urandom), $urandom_range(1, 5), $urandom_range(20, 140));
    end
  endtask

  task automatic test_concurrent();
    int t0;
    logic [7:0] b, c;
    b = 8'($urandom); c = 8'($urandom);
    fork
      send_rx(b, 1'b1, t0);
      tx_frame(c, 2, 100);
    join
    m_byte(b, 1'b0);
    check_rx("concurrent");
    pulse_ack();
  endtask

  task automatic test_reset_midframe();
    int t0;
    logic [7:0] b;
    send_rx(8'($urandom), 1'b1, t0); m_byte(rx_data, 1'b0);
    send_rx(8'($urandom), 1'b1, t0); m_byte(8'h00, 1'b0);
    check_rx("pre_reset");
    @(negedge clk); tx_data = 8'h00; tx_we = 1'b1;
    @(negedge clk); tx_we = 1'b0; rxd = 1'b0;
    repeat (40) @(negedge clk);
    checks++;
    if (txd !== 1'b0 || write_ready !== 1'b0) begin
      failures++; $display("FAIL mid_frame txd/wr got=%b%b exp=00", txd, write_ready);
    end
    #2 rst = 1'b1;
    #1;
    m_reset();
    checks++;
    if ({txd, write_ready, read_ready, overrun} !== 4'b1100 || rx_data !== 8'h00) begin
      failures++;
      $display("FAIL async_reset txd/wr/rr/ovr got=%b%b%b%b rx_data=%h exp=1100/00",
               txd, write_ready, read_ready, overrun, rx_data);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0; rxd = 1'b1;
    repeat (200) @(negedge clk);
    check_rx("post_reset_idle");
    checks++;
    if (txd !== 1'b1) begin
      failures++; $display("FAIL post_reset txd got=%b exp=1", txd);
    end
    b = 8'($urandom);
    send_rx(b, 1'b1, t0); m_byte(b, 1'b0);
    check_rx("post_reset_rx");
    pulse_ack();
  endtask

  initial begin
    test_reset();
    test_rx_basic();
    test_glitch();
    test_overrun();
    test_frame_err();
    test_tx();
    test_concurrent();
    test_reset_midframe();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
